// File: rtl/lcd_bus_arbiter.sv
// Write-only 8-bit LCD bus controller: runs the power-on init command sequence,
// then grants two write requesters round-robin and times each SETUP/EN/execution phase.
module lcd_bus_arbiter #(
  parameter int POR_CYC     = 2000000,
  parameter int SETUP_CYC   = 4,
  parameter int EN_HIGH_CYC = 25,
  parameter int EN_LOW_CYC  = 2500,
  parameter int CLR_CYC     = 100000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req0,
  input  logic       req1,
  input  logic       rs0,
  input  logic       rs1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  output logic       ack0,
  output logic       ack1,
  output logic       lcd_en,
  output logic       lcd_on,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_data,
  output logic       init_done,
  output logic       busy
);

  localparam int MAX_A   = (POR_CYC > CLR_CYC) ? POR_CYC : CLR_CYC;
  localparam int MAX_B   = (EN_LOW_CYC > EN_HIGH_CYC) ? EN_LOW_CYC : EN_HIGH_CYC;
  localparam int MAX_C   = (MAX_B > SETUP_CYC) ? MAX_B : SETUP_CYC;
  localparam int MAX_CYC = (MAX_A > MAX_C) ? MAX_A : MAX_C;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] POR_LAST   = CW'(POR_CYC - 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] HIGH_LAST  = CW'(EN_HIGH_CYC - 1);
  localparam logic [CW-1:0] LOW_LAST   = CW'(EN_LOW_CYC - 1);
  localparam logic [CW-1:0] CLR_LAST   = CW'(CLR_CYC - 1);
  localparam logic [2:0]    LAST_INIT  = 3'd4;

  typedef enum logic [2:0] {
    POR_WAIT,
    INIT,
    IDLE,
    SETUP,
    EN_HI,
    EN_LO
  } state_t;

  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0:    return 8'h38;
      3'd1:    return 8'h0C;
      3'd2:    return 8'h06;
      3'd3:    return 8'h01;
      default: return 8'h80;
    endcase
  endfunction

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic          gnt_q, gnt_d;
  logic          last_q, last_d;
  logic          rs_q, rs_d;
  logic [7:0]    data_q, data_d;
  logic          init_done_q, init_done_d;

  logic          is_clr;
  logic [CW-1:0] lo_last;
  logic          lo_end;
  logic          pick;

  // Clear/home commands need the long execution wait before the next write.
  assign is_clr  = !rs_q && (data_q == 8'h01 || data_q == 8'h02);
  assign lo_last = is_clr ? CLR_LAST : LOW_LAST;
  assign lo_end  = (state_q == EN_LO) && (cnt_q == lo_last);
  assign pick    = req1 && (!req0 || !last_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CW'(1);
    idx_d       = idx_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    rs_d        = rs_q;
    data_d      = data_q;
    init_done_d = init_done_q;
    case (state_q)
      POR_WAIT: begin
        if (cnt_q == POR_LAST) begin
          state_d = INIT;
          cnt_d   = '0;
        end
      end
      INIT: begin
        state_d = SETUP;
        cnt_d   = '0;
        idx_d   = '0;
        rs_d    = 1'b0;
        data_d  = init_cmd(3'd0);
      end
      IDLE: begin
        cnt_d = '0;
        if (req0 || req1) begin
          state_d = SETUP;
          gnt_d   = pick;
          last_d  = pick;
          rs_d    = pick ? rs1 : rs0;
          data_d  = pick ? data1 : data0;
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = EN_HI;
          cnt_d   = '0;
        end
      end
      EN_HI: begin
        if (cnt_q == HIGH_LAST) begin
          state_d = EN_LO;
          cnt_d   = '0;
        end
      end
      EN_LO: begin
        if (lo_end) begin
          cnt_d = '0;
          if (init_done_q) begin
            state_d = IDLE;
          end else if (idx_q == LAST_INIT) begin
            state_d     = IDLE;
            init_done_d = 1'b1;
          end else begin
            state_d = SETUP;
            idx_d   = idx_q + 3'd1;
            rs_d    = 1'b0;
            data_d  = init_cmd(idx_q + 3'd1);
          end
        end
      end
      default: begin
        state_d = POR_WAIT;
        cnt_d   = '0;
      end
    endcase
  end

  // last_q resets to 1 so the first contended grant goes to requester 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= POR_WAIT;
      cnt_q       <= '0;
      idx_q       <= '0;
      gnt_q       <= 1'b0;
      last_q      <= 1'b1;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
      init_done_q <= init_done_d;
    end
  end

  assign lcd_en    = (state_q == EN_HI);
  assign lcd_rs    = rs_q;
  assign lcd_data  = data_q;
  assign lcd_on    = 1'b1;
  assign lcd_rw    = 1'b0;
  assign ack0      = lo_end && init_done_q && !gnt_q;
  assign ack1      = lo_end && init_done_q && gnt_q;
  assign init_done = init_done_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Self-checking bench for lcd_bus_arbiter: a bus monitor records EN pulses and acks,
// and a transaction-level model predicts the grant order and cycle timing.
module tb_lcd_bus_arbiter;

  localparam int POR     = 20;
  localparam int SETUP   = 2;
  localparam int EN_HIGH = 3;
  localparam int EN_LOW  = 4;
  localparam int CLR     = 10;

  typedef struct {
    int         rise;
    int         width;
    logic       rs;
    logic [7:0] data;
  } pulseRec;

  typedef struct {
    int   cyc;
    logic who;
  } ackRec;

  typedef struct {
    logic       who;
    logic       rs;
    logic [7:0] data;
    int         rise;
    int         ack;
  } expRec;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req0, req1, rs0, rs1;
  logic [7:0] data0, data1;
  logic       ack0, ack1, lcd_en, lcd_on, lcd_rs, lcd_rw, init_done, busy;
  logic [7:0] lcd_data;

  int         compared = 0;
  int         mismatched = 0;
  int         cyc = 0;
  pulseRec    pulseQ[$];
  ackRec      ackQ[$];
  logic [8:0] b0[$];
  logic [8:0] b1[$];
  logic       modelLast;
  logic [7:0] initCmd[5] = '{8'h38, 8'h0C, 8'h06, 8'h01, 8'h80};

  lcd_bus_arbiter #(
    .POR_CYC    (POR),
    .SETUP_CYC  (SETUP),
    .EN_HIGH_CYC(EN_HIGH),
    .EN_LOW_CYC (EN_LOW),
    .CLR_CYC    (CLR)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req0     (req0),
    .req1     (req1),
    .rs0      (rs0),
    .rs1      (rs1),
    .data0    (data0),
    .data1    (data1),
    .ack0     (ack0),
    .ack1     (ack1),
    .lcd_en   (lcd_en),
    .lcd_on   (lcd_on),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_data (lcd_data),
    .init_done(init_done),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic int postWait(input logic rs, input logic [7:0] d);
    return (!rs && (d == 8'h01 || d == 8'h02)) ? CLR : EN_LOW;
  endfunction

  // Bus monitor: records every EN pulse and ack, and checks the always-true bus rules.
  initial begin
    pulseRec cur;
    ackRec   a;
    logic    prevEn;
    prevEn = 1'b0;
    cur    = '{0, 0, 1'b0, 8'h00};
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prevEn = 1'b0;
      end else begin
        checkOutput("rwOn", {30'd0, lcd_rw, lcd_on}, 32'd1);
        if (!init_done) checkOutput("ackInInit", {30'd0, ack0, ack1}, 32'd0);
        if (lcd_en && !prevEn) begin
          cur.rise = cyc;
          cur.rs   = lcd_rs;
          cur.data = lcd_data;
        end
        if (!lcd_en && prevEn) begin
          cur.width = cyc - cur.rise;
          checkOutput("holdAtFall", {lcd_rs, lcd_data}, {cur.rs, cur.data});
          pulseQ.push_back(cur);
        end
        if (ack0 || ack1) begin
          checkOutput("oneAck", ack0 & ack1, 0);
          if (pulseQ.size() > 0)
            checkOutput("holdAtAck", {lcd_rs, lcd_data},
                        {pulseQ[pulseQ.size()-1].rs, pulseQ[pulseQ.size()-1].data});
          a.cyc = cyc;
          a.who = ack1;
          ackQ.push_back(a);
        end
        prevEn = lcd_en;
      end
    end
  end

  // Drives each requester from the front of its pending queue; junk data when idle.
  task automatic applyStimulus();
    req0 = (b0.size() > 0);
    req1 = (b1.size() > 0);
    if (b0.size() > 0) {rs0, data0} = b0[0];
    else               {rs0, data0} = 9'($urandom);
    if (b1.size() > 0) {rs1, data1} = b1[0];
    else               {rs1, data1} = 9'($urandom);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, ":en"}, lcd_en, 0);
    checkOutput({tag, ":rsData"}, {lcd_rs, lcd_data}, 0);
    checkOutput({tag, ":acks"}, {ack0, ack1}, 0);
    checkOutput({tag, ":initDone"}, init_done, 0);
    checkOutput({tag, ":busy"}, busy, 1);
    checkOutput({tag, ":rwOn"}, {lcd_rw, lcd_on}, 1);
  endtask

  // Called on the negedge where reset_n was released; checks the whole init sequence.
  task automatic runInitCheck(input bit withReq);
    int r, i, d;
    r = cyc;
    pulseQ.delete();
    ackQ.delete();
    modelLast = 1'b1;
    if (withReq) begin
      req0  = 1'b1;
      rs0   = 1'b1;
      data0 = 8'h41;
    end
    for (int k = 0; k < 400 && !init_done; k++) @(negedge clk);
    checkOutput("initDoneSeen", init_done, 1);
    i = cyc;
    checkOutput("busyAtInitDone", busy, 0);
    checkOutput("initPulseCount", pulseQ.size(), 5);
    for (int k = 0; k < 5 && k < pulseQ.size(); k++) begin
      checkOutput("initData", pulseQ[k].data, initCmd[k]);
      checkOutput("initRs", pulseQ[k].rs, 0);
      checkOutput("initWidth", pulseQ[k].width, EN_HIGH);
      if (k > 0)
        checkOutput("initGap", pulseQ[k].rise - pulseQ[k-1].rise,
                    EN_HIGH + postWait(1'b0, initCmd[k-1]) + SETUP);
    end
    if (pulseQ.size() > 0) begin
      d = pulseQ[0].rise - r;
      checkOutput("porWait", (d >= POR + SETUP && d <= POR + SETUP + 2), 1);
    end
    if (pulseQ.size() == 5)
      checkOutput("initDoneDelay", i - pulseQ[4].rise, EN_HIGH + EN_LOW);
    if (withReq) begin
      for (int k = 0; k < 50 && !ack0; k++) @(negedge clk);
      checkOutput("lateReqAck", ack0, 1);
      checkOutput("lateReqAckCycle", cyc - i, SETUP + EN_HIGH + EN_LOW);
      if (pulseQ.size() == 6)
        checkOutput("lateReqData", {pulseQ[5].rs, pulseQ[5].data}, 9'h141);
      else
        checkOutput("lateReqPulses", pulseQ.size(), 6);
      req0 = 1'b0;
      modelLast = 1'b0;
    end
  endtask

  // Serves the queued writes in b0/b1 and compares against the transaction model.
  task automatic runBatch(input string name);
    expRec      expQ[$];
    expRec      e;
    logic [8:0] m0[$];
    logic [8:0] m1[$];
    logic [8:0] item;
    logic       pick;
    int         s, g, post, budget;
    m0 = b0;
    m1 = b1;
    @(negedge clk);
    pulseQ.delete();
    ackQ.delete();
    s = cyc;
    g = s;
    while (m0.size() > 0 || m1.size() > 0) begin
      if (m0.size() > 0 && m1.size() > 0) pick = !modelLast;
      else                                pick = (m0.size() == 0);
      item   = pick ? m1.pop_front() : m0.pop_front();
      post   = postWait(item[8], item[7:0]);
      e.who  = pick;
      e.rs   = item[8];
      e.data = item[7:0];
      e.rise = g + SETUP + 1;
      e.ack  = g + SETUP + EN_HIGH + post;
      expQ.push_back(e);
      modelLast = pick;
      g = e.ack + 1;
    end
    applyStimulus();
    budget = g - s + 40;
    for (int k = 0; k < budget && (b0.size() > 0 || b1.size() > 0); k++) begin
      @(negedge clk);
      if (k == 0 && expQ.size() > 0)
        checkOutput({name, ":latchNext"}, {lcd_rs, lcd_data}, {expQ[0].rs, expQ[0].data});
      if (ack0 && b0.size() > 0) void'(b0.pop_front());
      if (ack1 && b1.size() > 0) void'(b1.pop_front());
      applyStimulus();
    end
    checkOutput({name, ":drained"}, b0.size() + b1.size(), 0);
    b0.delete();
    b1.delete();
    applyStimulus();
    repeat (2) @(negedge clk);
    checkOutput({name, ":ackCount"}, ackQ.size(), expQ.size());
    checkOutput({name, ":pulseCount"}, pulseQ.size(), expQ.size());
    for (int i = 0; i < expQ.size(); i++) begin
      if (i < ackQ.size()) begin
        checkOutput({name, ":ackWho"}, ackQ[i].who, expQ[i].who);
        checkOutput({name, ":ackCycle"}, ackQ[i].cyc - s, expQ[i].ack - s);
      end
      if (i < pulseQ.size()) begin
        checkOutput({name, ":data"}, {pulseQ[i].rs, pulseQ[i].data}, {expQ[i].rs, expQ[i].data});
        checkOutput({name, ":rise"}, pulseQ[i].rise - s, expQ[i].rise - s);
        checkOutput({name, ":width"}, pulseQ[i].width, EN_HIGH);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: reset, init with an early request, directed cases, random batches,
  // then a reset in the middle of a transfer.
  initial begin
    int s, n0, n1;
    logic       rsR;
    logic [7:0] dR;
    reset_n   = 1'b0;
    req0      = 1'b0;
    req1      = 1'b0;
    rs0       = 1'b0;
    rs1       = 1'b0;
    data0     = 8'h00;
    data1     = 8'h00;
    modelLast = 1'b1;
    repeat (3) @(negedge clk);
    checkReset("reset");
    reset_n = 1'b1;
    runInitCheck(1);

    b0.push_back(9'h141);
    runBatch("single");

    @(negedge clk);
    s = cyc;
    req0  = 1'b1;
    rs0   = 1'b1;
    data0 = 8'h5A;
    @(negedge clk);
    checkOutput("dropLatch", {lcd_rs, lcd_data}, 9'h15A);
    req0  = 1'b0;
    rs0   = 1'b0;
    data0 = 8'hFF;
    for (int k = 0; k < 30 && !ack0; k++) @(negedge clk);
    checkOutput("dropAck", ack0, 1);
    checkOutput("dropAckCycle", cyc - s, SETUP + EN_HIGH + EN_LOW);
    modelLast = 1'b0;

    b1.push_back(9'h001);
    runBatch("clear");

    b0.push_back(9'h131);
    b0.push_back(9'h132);
    b1.push_back(9'h161);
    b1.push_back(9'h162);
    runBatch("contend");

    for (int n = 0; n < 4; n++) begin
      n0 = $urandom_range(0, 3);
      n1 = $urandom_range(1, 3);
      for (int j = 0; j < n0 + n1; j++) begin
        rsR = 1'($urandom_range(0, 1));
        dR  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 2)) : 8'($urandom);
        if (j < n0) b0.push_back({rsR, dR});
        else        b1.push_back({rsR, dR});
      end
      runBatch("random");
    end

    @(negedge clk);
    req1  = 1'b1;
    rs1   = 1'b1;
    data1 = 8'h33;
    for (int k = 0; k < 20 && !lcd_en; k++) @(negedge clk);
    checkOutput("midEnSeen", lcd_en, 1);
    reset_n = 1'b0;
    #1;
    checkReset("midReset");
    req1 = 1'b0;
    repeat (3) @(negedge clk);
    checkReset("midResetHold");
    reset_n = 1'b1;
    runInitCheck(0);

    b0.push_back(9'h1AA);
    b1.push_back(9'h1BB);
    runBatch("afterReset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
